// File: rtl/bp_be_rv64_pkg.sv
// RV64 backend types shared by the instruction unpacker: raw instruction layout,
// architectural widths and the queue entry {pc, instr}.
`ifndef BP_BE_RV64_PKG_SV
`define BP_BE_RV64_PKG_SV

// Entry layout is declared by macro so each user can size the PC to its own eaddr width.
`define BP_BE_DECLARE_ISSUE_ENTRY_S(eaddr_width_mp, struct_name_mp) \
   typedef struct packed {                                           \
      logic [eaddr_width_mp-1:0] pc;                                 \
      bp_be_instr_s              instr;                              \
   } struct_name_mp

package bp_be_rv64_pkg;

   localparam int rv64_instr_width_gp = 32;
   localparam int rv64_eaddr_width_gp = 64;
   localparam int rv64_instr_bytes_gp = 4;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } bp_be_instr_s;

   `BP_BE_DECLARE_ISSUE_ENTRY_S(rv64_eaddr_width_gp, bp_be_issue_entry_s);

endpackage

`endif

// File: rtl/bp_be_instr_unpacker_if.sv
// Fetch-packet and issue handshake bundle between front end, unpacker and issue stage.
interface bp_be_instr_unpacker_if
  #(parameter int fetch_width_p = 2,
    parameter int depth_p       = 8,
    parameter int eaddr_width_p = bp_be_rv64_pkg::rv64_eaddr_width_gp)
   ();

   localparam int count_width_lp = $clog2(depth_p + 1);

   logic                                                      fe_v_i;
   logic                                                      fe_ready_o;
   logic [eaddr_width_p-1:0]                                  fe_pc_i;
   logic [fetch_width_p*bp_be_rv64_pkg::rv64_instr_width_gp-1:0] fe_instr_i;
   logic [fetch_width_p-1:0]                                  fe_mask_i;
   logic                                                      flush_i;

   logic                                                      issue_v_o;
   logic                                                      issue_yumi_i;
   bp_be_rv64_pkg::bp_be_instr_s                              issue_instr_o;
   logic [eaddr_width_p-1:0]                                  issue_pc_o;
   logic                                                      issue_illegal_o;
   logic [count_width_lp-1:0]                                 count_o;

   modport master (
      output fe_v_i, fe_pc_i, fe_instr_i, fe_mask_i, flush_i, issue_yumi_i,
      input  fe_ready_o, issue_v_o, issue_instr_o, issue_pc_o, issue_illegal_o, count_o
   );

   modport slave (
      input  fe_v_i, fe_pc_i, fe_instr_i, fe_mask_i, flush_i, issue_yumi_i,
      output fe_ready_o, issue_v_o, issue_instr_o, issue_pc_o, issue_illegal_o, count_o
   );

endinterface

// File: rtl/bp_be_instr_compact.sv
// Combinational lane compactor: packs the valid lanes of a fetch packet toward slot 0
// in ascending lane order, carrying each lane's own PC along.
module bp_be_instr_compact
   import bp_be_rv64_pkg::*;
  #(parameter int fetch_width_p = 2,
    parameter int eaddr_width_p = rv64_eaddr_width_gp,
    localparam int pop_width_lp = $clog2(fetch_width_p + 1))
   (input  logic [fetch_width_p-1:0]                     mask_i,
    input  logic [fetch_width_p*rv64_instr_width_gp-1:0] instr_i,
    input  logic [eaddr_width_p-1:0]                     pc_i,
    output bp_be_instr_s                                 instr_o [fetch_width_p],
    output logic [eaddr_width_p-1:0]                     pc_o [fetch_width_p],
    output logic [pop_width_lp-1:0]                      popcount_o);

   logic [pop_width_lp-1:0] prefix [fetch_width_p];
   logic [pop_width_lp-1:0] running;

   // prefix[k] is the destination slot of lane k: number of valid lanes below it.
   always_comb begin
      // NOTE: blocking assignments here build a combinational chain through running;
      // non-blocking would read the stale value on every iteration.
      running = '0;
      for (int k = 0; k < fetch_width_p; k++) begin
         prefix[k] = running;
         running   = running + pop_width_lp'(mask_i[k]);
      end
      popcount_o = running;
   end

   always_comb begin
      // NOTE: every output gets a default before the select loop, so slots that no
      // lane lands in are driven and no latch is inferred.
      for (int j = 0; j < fetch_width_p; j++) begin
         instr_o[j] = '0;
         pc_o[j]    = '0;
      end
      for (int j = 0; j < fetch_width_p; j++) begin
         for (int k = 0; k < fetch_width_p; k++) begin
            if (mask_i[k] && (prefix[k] == pop_width_lp'(j))) begin
               instr_o[j] = bp_be_instr_s'(instr_i[k*rv64_instr_width_gp +: rv64_instr_width_gp]);
               pc_o[j]    = pc_i + eaddr_width_p'(rv64_instr_bytes_gp * k);
            end
         end
      end
   end

endmodule

// File: rtl/bp_be_instr_unpacker.sv
// Instruction buffer: compacts masked fetch packets into a circular single-instruction
// queue and issues one instruction per cycle with its PC and an illegal-encoding flag.
module bp_be_instr_unpacker
   import bp_be_rv64_pkg::*;
  #(parameter int fetch_width_p = 2,
    parameter int depth_p       = 8,
    parameter int eaddr_width_p = rv64_eaddr_width_gp)
   (input logic                    clk_i,
    input logic                    reset_n_i,
    bp_be_instr_unpacker_if.slave  io);

   localparam int ptr_width_lp   = (depth_p > 1) ? $clog2(depth_p) : 1;
   localparam int count_width_lp = $clog2(depth_p + 1);
   localparam int pop_width_lp   = $clog2(fetch_width_p + 1);
   localparam logic [ptr_width_lp-1:0] ptr_mask_lp = ptr_width_lp'(depth_p - 1);

   `BP_BE_DECLARE_ISSUE_ENTRY_S(eaddr_width_p, issue_entry_s);

   issue_entry_s              mem_r [depth_p];
   logic [ptr_width_lp-1:0]   head_r;
   logic [ptr_width_lp-1:0]   tail_r;
   logic [count_width_lp-1:0] count_r;

   bp_be_instr_s              lane_instr [fetch_width_p];
   logic [eaddr_width_p-1:0]  lane_pc [fetch_width_p];
   logic [pop_width_lp-1:0]   lane_count;
   logic [pop_width_lp-1:0]   accept_count;

   logic has_room;
   logic accept;
   logic deq;
   issue_entry_s head_entry;

   bp_be_instr_compact
     #(.fetch_width_p(fetch_width_p),
       .eaddr_width_p(eaddr_width_p))
   compact
     (.mask_i    (io.fe_mask_i),
      .instr_i   (io.fe_instr_i),
      .pc_i      (io.fe_pc_i),
      .instr_o   (lane_instr),
      .pc_o      (lane_pc),
      .popcount_o(lane_count));

   // Credit comes only from the registered count; a same-cycle pop does not help.
   assign has_room      = (depth_p - int'(count_r)) >= fetch_width_p;
   assign io.fe_ready_o = reset_n_i & has_room;
   assign io.issue_v_o  = reset_n_i & (count_r != '0);

   assign accept       = io.fe_v_i & io.fe_ready_o & ~io.flush_i;
   assign deq          = io.issue_yumi_i & io.issue_v_o & ~io.flush_i;
   assign accept_count = accept ? lane_count : '0;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i || io.flush_i) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         head_r  <= (head_r + ptr_width_lp'(deq)) & ptr_mask_lp;
         tail_r  <= (tail_r + ptr_width_lp'(accept_count)) & ptr_mask_lp;
         count_r <= count_r + count_width_lp'(accept_count) - count_width_lp'(deq);
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by count_r alone,
   // so stale slot contents are never observable as issued instructions.
   always_ff @(posedge clk_i) begin
      for (int j = 0; j < fetch_width_p; j++) begin
         if (accept && (pop_width_lp'(j) < lane_count)) begin
            mem_r[(tail_r + ptr_width_lp'(j)) & ptr_mask_lp] <= '{pc: lane_pc[j], instr: lane_instr[j]};
         end
      end
   end

   assign head_entry         = mem_r[head_r];
   assign io.issue_instr_o   = head_entry.instr;
   assign io.issue_pc_o      = head_entry.pc;
   assign io.issue_illegal_o = (head_entry.instr.opcode[1:0] != 2'b11);
   assign io.count_o         = count_r;

endmodule

// File: tb/tb_bp_be_instr_unpacker.sv
// Self-checking bench for bp_be_instr_unpacker: directed scenarios plus a randomized run,
// all compared against a queue-based reference model.
module tb_bp_be_instr_unpacker;
   import bp_be_rv64_pkg::*;

   localparam int fw = 2;
   localparam int dp = 8;
   localparam int ew = 64;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   bp_be_instr_unpacker_if #(.fetch_width_p(fw), .depth_p(dp), .eaddr_width_p(ew)) dut_if ();

   bp_be_instr_unpacker #(.fetch_width_p(fw), .depth_p(dp), .eaddr_width_p(ew)) dut
     (.clk_i(clk), .reset_n_i(reset_n), .io(dut_if.slave));

   int n_cmp = 0;
   int n_fail = 0;
   int proto_err = 0;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;
   ent_t q[$];

   // A consumer taking from an empty buffer is a protocol violation.
   always @(posedge clk) begin
      if (reset_n === 1'b1 && dut_if.issue_yumi_i === 1'b1 && dut_if.issue_v_o !== 1'b1) begin
         proto_err = proto_err + 1;
         $display("FAIL protocol: yumi asserted while issue_v_o=%b", dut_if.issue_v_o);
      end
   end

   function automatic bit m_ready();
      return (dp - q.size()) >= fw;
   endfunction

   task automatic idle();
      dut_if.fe_v_i       = 1'b0;
      dut_if.fe_mask_i    = '0;
      dut_if.fe_pc_i      = '0;
      dut_if.fe_instr_i   = '0;
      dut_if.flush_i      = 1'b0;
      dut_if.issue_yumi_i = 1'b0;
      reset_n             = 1'b1;
   endtask

   // Applies one cycle of inputs, advances the reference model, then returns to idle.
   task automatic drive_cycle(input bit v, input logic [1:0] mask, input logic [63:0] pc,
                              input logic [63:0] instr, input bit flush, input bit yumi,
                              input bit rstn);
      bit   rdy;
      ent_t e;
      dut_if.fe_v_i       = v;
      dut_if.fe_mask_i    = mask;
      dut_if.fe_pc_i      = pc;
      dut_if.fe_instr_i   = instr;
      dut_if.flush_i      = flush;
      dut_if.issue_yumi_i = yumi;
      reset_n             = rstn;
      @(posedge clk);
      if (!rstn || flush) begin
         q.delete();
      end else begin
         rdy = m_ready();
         if (yumi && q.size() != 0) q.delete(0);
         if (v && rdy) begin
            for (int k = 0; k < fw; k++) begin
               if (mask[k]) begin
                  e.pc    = pc + 64'(4 * k);
                  e.instr = instr[32*k +: 32];
                  q.push_back(e);
               end
            end
         end
      end
      #1;
      idle();
      #1;
   endtask

   function automatic logic [63:0] rand_instrs();
      return {$urandom(), $urandom()};
   endfunction

   task automatic test_reset();
      idle();
      reset_n = 1'b0;
      #1;
      n_cmp++; if (dut_if.fe_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_during: got %b want 0", dut_if.fe_ready_o); end
      n_cmp++; if (dut_if.issue_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v_during: got %b want 0", dut_if.issue_v_o); end
      drive_cycle(0, 2'b00, 64'h0, 64'h0, 0, 0, 0);
      n_cmp++; if (dut_if.fe_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", dut_if.fe_ready_o); end
      n_cmp++; if (dut_if.issue_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v_after: got %b want 0", dut_if.issue_v_o); end
      n_cmp++; if (dut_if.count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count_after: got %0d want 0", dut_if.count_o); end
   endtask

   task automatic test_pair();
      drive_cycle(1, 2'b11, 64'h1000, {32'h0000_0013, 32'h00B5_0533}, 0, 0, 1);
      n_cmp++; if (dut_if.issue_v_o !== 1'b1) begin n_fail++; $display("FAIL pair_v: got %b want 1", dut_if.issue_v_o); end
      n_cmp++; if (dut_if.count_o !== 4'd2) begin n_fail++; $display("FAIL pair_count0: got %0d want 2", dut_if.count_o); end
      n_cmp++; if (dut_if.issue_pc_o !== 64'h1000) begin n_fail++; $display("FAIL pair_pc0: got %h want 1000", dut_if.issue_pc_o); end
      n_cmp++; if (dut_if.issue_instr_o !== 32'h00B5_0533) begin n_fail++; $display("FAIL pair_instr0: got %h want 00b50533", dut_if.issue_instr_o); end
      drive_cycle(0, 2'b00, 64'h0, 64'h0, 0, 1, 1);
      n_cmp++; if (dut_if.count_o !== 4'd1) begin n_fail++; $display("FAIL pair_count1: got %0d want 1", dut_if.count_o); end
      n_cmp++; if (dut_if.issue_pc_o !== 64'h1004) begin n_fail++; $display("FAIL pair_pc1: got %h want 1004", dut_if.issue_pc_o); end
      n_cmp++; if (dut_if.issue_instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL pair_instr1: got %h want 00000013", dut_if.issue_instr_o); end
      drive_cycle(0, 2'b00, 64'h0, 64'h0, 0, 1, 1);
      n_cmp++; if (dut_if.count_o !== 4'd0) begin n_fail++; $display("FAIL pair_count2: got %0d want 0", dut_if.count_o); end
      n_cmp++; if (dut_if.issue_v_o !== 1'b0) begin n_fail++; $display("FAIL pair_v_empty: got %b want 0", dut_if.issue_v_o); end
   endtask

   task automatic test_single_lane();
      drive_cycle(1, 2'b10, 64'h2000, {32'h00C5_8593, 32'hDEAD_BEEF}, 0, 0, 1);
      n_cmp++; if (dut_if.count_o !== 4'd1) begin n_fail++; $display("FAIL lane1_count: got %0d want 1", dut_if.count_o); end
      n_cmp++; if (dut_if.issue_pc_o !== 64'h2004) begin n_fail++; $display("FAIL lane1_pc: got %h want 2004", dut_if.issue_pc_o); end
      n_cmp++; if (dut_if.issue_instr_o !== 32'h00C5_8593) begin n_fail++; $display("FAIL lane1_instr: got %h want 00c58593", dut_if.issue_instr_o); end
      drive_cycle(1, 2'b00, 64'h3000, rand_instrs(), 0, 1, 1);
      n_cmp++; if (dut_if.count_o !== 4'd0) begin n_fail++; $display("FAIL zero_mask_count: got %0d want 0", dut_if.count_o); end
   endtask

   task automatic test_fill_wrap();
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1, 2'b11, 64'h8000 + 64'(i * 8), rand_instrs(), 0, 0, 1);
         n_cmp++; if (dut_if.count_o !== 4'(q.size())) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, dut_if.count_o, q.size()); end
         n_cmp++; if (dut_if.fe_ready_o !== m_ready()) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b want %b", i, dut_if.fe_ready_o, m_ready()); end
      end
      n_cmp++; if (dut_if.fe_ready_o !== 1'b0 || dut_if.count_o !== 4'd8) begin n_fail++; $display("FAIL full_state: ready %b count %0d want ready 0 count 8", dut_if.fe_ready_o, dut_if.count_o); end
      drive_cycle(1, 2'b11, 64'h9000, rand_instrs(), 0, 1, 1);
      n_cmp++; if (dut_if.count_o !== 4'd7 || dut_if.fe_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_pop: count %0d ready %b want count 7 ready 0", dut_if.count_o, dut_if.fe_ready_o); end
      drive_cycle(0, 2'b00, 64'h0, 64'h0, 0, 1, 1);
      n_cmp++; if (dut_if.count_o !== 4'd6 || dut_if.fe_ready_o !== 1'b1) begin n_fail++; $display("FAIL pop_to6: count %0d ready %b want count 6 ready 1", dut_if.count_o, dut_if.fe_ready_o); end
      drive_cycle(1, 2'b11, 64'hA000, rand_instrs(), 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (dut_if.issue_v_o !== 1'b1 || dut_if.issue_pc_o !== q[0].pc) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, dut_if.issue_pc_o, q[0].pc); end
         n_cmp++; if (dut_if.issue_instr_o !== q[0].instr) begin n_fail++; $display("FAIL wrap_instr[%0d]: got %h want %h", i, dut_if.issue_instr_o, q[0].instr); end
         drive_cycle(0, 2'b00, 64'h0, 64'h0, 0, 1, 1);
      end
      n_cmp++; if (dut_if.count_o !== 4'd0) begin n_fail++; $display("FAIL wrap_drain: got %0d want 0", dut_if.count_o); end
   endtask

   task automatic test_flush();
      drive_cycle(1, 2'b11, 64'hB000, rand_instrs(), 0, 0, 1);
      drive_cycle(1, 2'b11, 64'hB008, rand_instrs(), 0, 0, 1);
      drive_cycle(1, 2'b01, 64'hB010, rand_instrs(), 0, 0, 1);
      n_cmp++; if (dut_if.count_o !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 5", dut_if.count_o); end
      drive_cycle(1, 2'b11, 64'hC000, rand_instrs(), 1, 1, 1);
      n_cmp++; if (dut_if.count_o !== 4'd0 || dut_if.issue_v_o !== 1'b0) begin n_fail++; $display("FAIL flush_state: count %0d v %b want 0 0", dut_if.count_o, dut_if.issue_v_o); end
      drive_cycle(0, 2'b00, 64'h0, 64'h0, 0, 0, 1);
      n_cmp++; if (dut_if.count_o !== 4'd0) begin n_fail++; $display("FAIL flush_dropped: got %0d want 0", dut_if.count_o); end
   endtask

   task automatic test_compressed();
      drive_cycle(1, 2'b01, 64'hD000, {32'h0000_0013, 32'h0000_4501}, 0, 0, 1);
      n_cmp++; if (dut_if.issue_v_o !== 1'b1 || dut_if.issue_illegal_o !== 1'b1) begin n_fail++; $display("FAIL compressed_flag: v %b illegal %b want 1 1", dut_if.issue_v_o, dut_if.issue_illegal_o); end
      n_cmp++; if (dut_if.issue_instr_o !== 32'h0000_4501) begin n_fail++; $display("FAIL compressed_instr: got %h want 00004501", dut_if.issue_instr_o); end
      drive_cycle(0, 2'b00, 64'h0, 64'h0, 0, 1, 1);
      n_cmp++; if (dut_if.count_o !== 4'd0) begin n_fail++; $display("FAIL compressed_consumed: got %0d want 0", dut_if.count_o); end
   endtask

   task automatic test_pc_wrap();
      drive_cycle(1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFC, rand_instrs(), 0, 0, 1);
      drive_cycle(0, 2'b00, 64'h0, 64'h0, 0, 1, 1);
      n_cmp++; if (dut_if.issue_pc_o !== 64'h0) begin n_fail++; $display("FAIL pc_wrap: got %h want 0", dut_if.issue_pc_o); end
      drive_cycle(0, 2'b00, 64'h0, 64'h0, 0, 1, 1);
   endtask

   task automatic test_mid_reset();
      drive_cycle(1, 2'b11, 64'hE000, rand_instrs(), 0, 0, 1);
      drive_cycle(1, 2'b11, 64'hE008, rand_instrs(), 0, 0, 1);
      n_cmp++; if (dut_if.count_o !== 4'd4) begin n_fail++; $display("FAIL midreset_pre: got %0d want 4", dut_if.count_o); end
      reset_n = 1'b0;
      #1;
      n_cmp++; if (dut_if.fe_ready_o !== 1'b0 || dut_if.issue_v_o !== 1'b0) begin n_fail++; $display("FAIL midreset_gating: ready %b v %b want 0 0", dut_if.fe_ready_o, dut_if.issue_v_o); end
      drive_cycle(0, 2'b00, 64'h0, 64'h0, 0, 0, 0);
      n_cmp++; if (dut_if.count_o !== 4'd0 || dut_if.fe_ready_o !== 1'b1) begin n_fail++; $display("FAIL midreset_after: count %0d ready %b want 0 1", dut_if.count_o, dut_if.fe_ready_o); end
   endtask

   task automatic test_random();
      bit          v, yumi, flush;
      logic [1:0]  mask;
      logic [63:0] pc;
      for (int i = 0; i < 400; i++) begin
         n_cmp++; if (dut_if.count_o !== 4'(q.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, dut_if.count_o, q.size()); end
         n_cmp++; if (dut_if.fe_ready_o !== m_ready()) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, dut_if.fe_ready_o, m_ready()); end
         n_cmp++; if (dut_if.issue_v_o !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_v[%0d]: got %b want %b", i, dut_if.issue_v_o, q.size() != 0); end
         if (q.size() != 0) begin
            n_cmp++; if (dut_if.issue_pc_o !== q[0].pc) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h want %h", i, dut_if.issue_pc_o, q[0].pc); end
            n_cmp++; if (dut_if.issue_instr_o !== q[0].instr) begin n_fail++; $display("FAIL rand_instr[%0d]: got %h want %h", i, dut_if.issue_instr_o, q[0].instr); end
            n_cmp++; if (dut_if.issue_illegal_o !== (q[0].instr[1:0] != 2'b11)) begin n_fail++; $display("FAIL rand_illegal[%0d]: got %b want %b", i, dut_if.issue_illegal_o, q[0].instr[1:0] != 2'b11); end
         end
         v     = ($urandom_range(0, 3) != 0);
         mask  = 2'($urandom_range(0, 3));
         yumi  = (q.size() != 0) && ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 24) == 0);
         pc    = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : ({$urandom(), $urandom()} & ~64'h3);
         drive_cycle(v, mask, pc, rand_instrs(), flush, yumi, 1);
      end
   endtask

   initial begin
      idle();
      reset_n = 1'b0;
      test_reset();
      test_pair();
      test_single_lane();
      test_fill_wrap();
      test_flush();
      test_compressed();
      test_pc_wrap();
      test_mid_reset();
      test_random();
      n_cmp++; if (proto_err !== 0) begin n_fail++; $display("FAIL protocol_count: got %0d want 0", proto_err); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/bp_be_instr_unpacker.md
# bp_be_instr_unpacker

Parametrised instruction buffer between the front-end fetch interface and the backend issue stage. Accepts packets of up to `fetch_width_p` 32-bit RV64 instructions with a per-lane valid mask, compacts valid lanes in order, stores them in a circular queue of `depth_p` single-instruction slots, and issues one `bp_be_instr_s` per cycle with its PC and an illegal-encoding flag. Supports a same-cycle flush for redirects.

## Interface
- `fetch_width_p`, 2: instruction lanes per fetch packet; must be ≥1.
- `depth_p`, 8: queue slots; power of 2, ≥ `fetch_width_p`.
- `eaddr_width_p`, 64: PC width (`rv64_eaddr_width_gp`).
- `clk_i` in 1: the single clock.
- `reset_n_i` in 1: synchronous, active-low reset.
- `fe_v_i` in 1: fetch packet valid.
- `fe_ready_o` out 1: the buffer can accept a full packet this cycle.
- `fe_pc_i` in `eaddr_width_p`: PC of lane 0; lane k PC = `fe_pc_i + 4k`.
- `fe_instr_i` in `fetch_width_p*32`: lane k in bits [32k+31:32k].
- `fe_mask_i` in `fetch_width_p`: per-lane valid; any pattern is allowed.
- `flush_i` in 1: discard all queued instructions.
- `issue_v_o` out 1: head entry valid.
- `issue_yumi_i` in 1: consumer takes head; legal only when `issue_v_o`=1.
- `issue_instr_o` out 32: head instruction as `bp_be_instr_s`.
- `issue_pc_o` out `eaddr_width_p`: head PC.
- `issue_illegal_o` out 1: head `opcode[1:0]` != 2'b11 (non-32-bit encoding).
- `count_o` out `$clog2(depth_p+1)`: current occupancy.

## Operation
- Accept when `fe_v_i & fe_ready_o` and not `flush_i`. Enqueue popcount(`fe_mask_i`) entries at the tail in ascending lane order, each with its own lane PC; the tail advances by that popcount modulo `depth_p`.
- `fe_v_i`=1 with an all-zero mask still completes the handshake and enqueues nothing.
- `fe_ready_o` = `(depth_p - count) >= fetch_width_p`, computed from the registered count. A same-cycle dequeue grants no extra credit.
- On dequeue (`issue_yumi_i`), the head advances by 1 modulo `depth_p`.
- Count update: `count + popcount(accepted mask) - yumi`. It never exceeds `depth_p` and never underflows. `issue_yumi_i` while empty is a protocol error; the bench asserts on it.
- `flush_i` has priority. Head, tail and count go to 0 next cycle, and any same-cycle enqueue or yumi is ignored. Storage contents are don't-care.
- PC arithmetic wraps modulo 2^`eaddr_width_p`.
- `issue_illegal_o` is informational only: the entry is still issued and consumed normally.

## Timing
- `issue_v_o` = `count != 0`.
- Issue outputs are driven combinationally from head storage. There is no bypass, so an instruction accepted in cycle t is first visible in cycle t+1.
- While `reset_n_i`=0: `fe_ready_o`=0 and `issue_v_o`=0, gated combinationally.
- At the clock edge with `reset_n_i`=0: head=0, tail=0, count=0. Storage is not reset.
- First cycle after reset: `fe_ready_o`=1, `issue_v_o`=0, `count_o`=0, `issue_illegal_o` don't-care.
- Reset asserted mid-operation behaves exactly like flush plus output gating.
- Full case: with count=`depth_p`, `fe_ready_o`=0 even if yumi is asserted.
- Empty case: a simultaneous accept and no yumi gives `issue_v_o`=1 next cycle.

## Structure
- In `bp_be_rv64_pkg`: reuse `bp_be_instr_s`, `rv64_instr_width_gp` and `rv64_eaddr_width_gp`. Add `localparam rv64_instr_bytes_gp = 4` and a packed `bp_be_issue_entry_s` {pc, instr} parametrised via the `eaddr` width macro.
- Sub-module `bp_be_instr_compact` (combinational):
  - Inputs: mask and lanes.
  - Outputs: compacted lanes, compacted PCs, and popcount, via a prefix-popcount select.
- The top holds the storage array, pointers, count and handshake logic.

## Test plan
- Reset, then fetch width 2, mask 2'b11, PC 0x1000, instrs {0x00B50533, 0x00000013}. Required: `issue_v_o`=1 the next cycle, PC 0x1000 then 0x1004, `count_o` 2→1→0 with yumi held.
- Mask 2'b10, PC 0x2000. Required: one entry, PC 0x2004, instr = lane 1.
- Fill to depth 8 with no yumi. Required: `fe_ready_o`=0 at count 7 and at 8. Pop one → count 7, ready stays 0; pop another → count 6, ready=1. Head and tail wrap past slot 7 correctly.
- Flush with `fe_v_i`=1 and `issue_yumi_i`=1 at count 5. Required: count 0, `issue_v_o`=0 next cycle, the packet is dropped.
- Lane instr 0x4501 (compressed). Required: `issue_illegal_o`=1, entry still issued and consumed.
- `reset_n_i`=0 for one cycle at count 4. Required: `fe_ready_o`=0 and `issue_v_o`=0 during reset, count 0 after.
